// File: rtl/rf_write_arbiter_if.sv
// Signal bundle between the pipeline (WB, long-latency unit, decode) and the register-file write arbiter.
// The arbiter takes the slave view; whoever drives the pipeline side takes the master view.
interface rf_write_arbiter_if;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        lu_valid;
  logic        lu_ready;
  logic [4:0]  lu_rd;
  logic [31:0] lu_data;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic [4:0]  chk_a1;
  logic [4:0]  chk_a2;
  logic [4:0]  chk_rd;
  logic        hazard_stall;
  logic        stall_req;
  logic        rf_we;
  logic [4:0]  rf_a3;
  logic [31:0] rf_wd;

  modport master (
    output wb_we, wb_rd, wb_data, lu_valid, lu_rd, lu_data,
           issue_valid, issue_rd, chk_a1, chk_a2, chk_rd,
    input  lu_ready, hazard_stall, stall_req, rf_we, rf_a3, rf_wd
  );

  modport slave (
    input  wb_we, wb_rd, wb_data, lu_valid, lu_rd, lu_data,
           issue_valid, issue_rd, chk_a1, chk_a2, chk_rd,
    output lu_ready, hazard_stall, stall_req, rf_we, rf_a3, rf_wd
  );
endinterface

// File: rtl/rf_write_arbiter.sv
// Shares the register-file write port between in-order WB and buffered long-latency results,
// with WB priority, starvation relief via stall_req, and a pending-register scoreboard for decode.
module rf_write_arbiter #(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic               clk,
  input  logic               rst,
  rf_write_arbiter_if.slave  bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [SW-1:0] STARVE_C = SW'(STARVE_LIMIT);

  logic [4:0]    r_fifo_rd   [DEPTH];
  logic [31:0]   r_fifo_data [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic [SW-1:0] r_starve;
  logic [31:0]   r_pending;

  logic        w_empty;
  logic        w_lu_ready;
  logic        w_stall;
  logic        w_wb_req;
  logic        w_head_grant;
  logic        w_wb_grant;
  logic        w_push;
  logic [4:0]  w_head_rd;
  logic [31:0] w_head_data;
  logic [31:0] w_pending_next;
  logic        w_hazard;

  always_comb begin
    w_empty      = (r_count == '0);
    w_lu_ready   = !rst && (r_count < DEPTH_C);
    w_stall      = !rst && !w_empty && (r_starve >= STARVE_C);
    w_wb_req     = bus.wb_we && (bus.wb_rd != 5'd0);
    w_head_grant = !rst && !w_empty && (w_stall || !w_wb_req);
    w_wb_grant   = !rst && !w_stall && w_wb_req;
    w_push       = bus.lu_valid && w_lu_ready && (bus.lu_rd != 5'd0);
    w_head_rd    = r_fifo_rd[r_rptr];
    w_head_data  = r_fifo_data[r_rptr];
  end

  // Clear before set so an issue to the register being retired this cycle stays pending.
  always_comb begin
    w_pending_next = r_pending;
    if (w_head_grant) begin
      w_pending_next[w_head_rd] = 1'b0;
    end
    if (bus.issue_valid && (bus.issue_rd != 5'd0)) begin
      w_pending_next[bus.issue_rd] = 1'b1;
    end
    w_pending_next[0] = 1'b0;
  end

  always_comb begin
    w_hazard = ((bus.chk_a1 != 5'd0) && r_pending[bus.chk_a1]) ||
               ((bus.chk_a2 != 5'd0) && r_pending[bus.chk_a2]) ||
               ((bus.chk_rd != 5'd0) && r_pending[bus.chk_rd]);
  end

  always_comb begin
    bus.lu_ready     = w_lu_ready;
    bus.stall_req    = w_stall;
    bus.hazard_stall = !rst && w_hazard;
    bus.rf_we        = w_head_grant || w_wb_grant;
    bus.rf_a3        = 5'd0;
    bus.rf_wd        = 32'd0;
    if (w_head_grant) begin
      bus.rf_a3 = w_head_rd;
      bus.rf_wd = w_head_data;
    end else if (w_wb_grant) begin
      bus.rf_a3 = bus.wb_rd;
      bus.rf_wd = bus.wb_data;
    end
  end

  // Storage needs no reset; validity is tracked by r_count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_rd[r_wptr]   <= bus.lu_rd;
      r_fifo_data[r_wptr] <= bus.lu_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_count   <= '0;
      r_starve  <= '0;
      r_pending <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_head_grant) begin
        r_rptr <= r_rptr + AW'(1);
      end
      if (w_push && !w_head_grant) begin
        r_count <= r_count + CW'(1);
      end else if (!w_push && w_head_grant) begin
        r_count <= r_count - CW'(1);
      end
      if (w_empty || w_head_grant) begin
        r_starve <= '0;
      end else if (r_starve < STARVE_C) begin
        r_starve <= r_starve + SW'(1);
      end
      r_pending <= w_pending_next;
    end
  end
endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed plus randomized bench for rf_write_arbiter against a queue-based reference model.
module tb_rf_write_arbiter;
  localparam int DEPTH        = 2;
  localparam int STARVE_LIMIT = 4;

  logic clk = 1'b0;
  logic rst;
  rf_write_arbiter_if bus ();

  rf_write_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state: buffered results in arrival order, head wait time, pending set.
  logic [4:0]  m_rd  [$];
  logic [31:0] m_dat [$];
  int          m_starve;
  bit          m_pend [32];

  logic        e_we, e_ready, e_stall, e_haz;
  logic [4:0]  e_a3;
  logic [31:0] e_wd;
  bit          e_pop;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_eval();
    bit empty, wbreq;
    empty = (m_rd.size() == 0);
    e_we = 0; e_a3 = 0; e_wd = 0; e_pop = 0; e_ready = 0; e_stall = 0; e_haz = 0;
    if (!rst) begin
      e_ready = (m_rd.size() < DEPTH);
      e_stall = !empty && (m_starve >= STARVE_LIMIT);
      wbreq   = bus.wb_we && (bus.wb_rd != 0);
      if (e_stall || (!wbreq && !empty)) begin
        e_pop = 1; e_we = 1; e_a3 = m_rd[0]; e_wd = m_dat[0];
      end else if (wbreq) begin
        e_we = 1; e_a3 = bus.wb_rd; e_wd = bus.wb_data;
      end
      e_haz = (bus.chk_a1 != 0 && m_pend[bus.chk_a1]) ||
              (bus.chk_a2 != 0 && m_pend[bus.chk_a2]) ||
              (bus.chk_rd != 0 && m_pend[bus.chk_rd]);
    end
  endtask

  task automatic model_update();
    bit was_empty;
    if (rst) begin
      m_rd.delete(); m_dat.delete(); m_starve = 0;
      for (int i = 0; i < 32; i++) m_pend[i] = 0;
    end else begin
      was_empty = (m_rd.size() == 0);
      if (e_pop) begin
        m_pend[m_rd[0]] = 0;
        void'(m_rd.pop_front());
        void'(m_dat.pop_front());
      end
      if (bus.issue_valid && bus.issue_rd != 0) m_pend[bus.issue_rd] = 1;
      if (bus.lu_valid && e_ready && bus.lu_rd != 0) begin
        m_rd.push_back(bus.lu_rd);
        m_dat.push_back(bus.lu_data);
      end
      if (was_empty || e_pop) m_starve = 0;
      else m_starve++;
    end
  endtask

  task automatic sample();
    @(negedge clk);
    model_eval();
    chk("rf_we", 32'(bus.rf_we), 32'(e_we));
    chk("rf_a3", 32'(bus.rf_a3), 32'(e_a3));
    chk("rf_wd", bus.rf_wd, e_wd);
    chk("lu_ready", 32'(bus.lu_ready), 32'(e_ready));
    chk("stall_req", 32'(bus.stall_req), 32'(e_stall));
    chk("hazard_stall", 32'(bus.hazard_stall), 32'(e_haz));
  endtask

  task automatic advance();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    sample();
    advance();
  endtask

  task automatic idle();
    bus.wb_we = 0; bus.wb_rd = 0; bus.wb_data = 0;
    bus.lu_valid = 0; bus.lu_rd = 0; bus.lu_data = 0;
    bus.issue_valid = 0; bus.issue_rd = 0;
    bus.chk_a1 = 0; bus.chk_a2 = 0; bus.chk_rd = 0;
  endtask

  task automatic lu(input logic [4:0] rd, input logic [31:0] d);
    bus.lu_valid = 1; bus.lu_rd = rd; bus.lu_data = d;
  endtask

  task automatic wb(input logic [4:0] rd, input logic [31:0] d);
    bus.wb_we = 1; bus.wb_rd = rd; bus.wb_data = d;
  endtask

  initial begin
    idle();
    rst = 1;
    tick(); tick();
    rst = 0;

    // Idle long-latency result goes straight through the FIFO next cycle
    lu(5, 32'hDEADBEEF);
    sample(); chk("idle_ready", 32'(bus.lu_ready), 1); advance();
    idle();
    sample();
    chk("idle_we", 32'(bus.rf_we), 1);
    chk("idle_a3", 32'(bus.rf_a3), 5);
    chk("idle_wd", bus.rf_wd, 32'hDEADBEEF);
    chk("idle_ready2", 32'(bus.lu_ready), 1);
    advance();
    sample(); chk("idle_drained", 32'(bus.rf_we), 0); advance();

    // x0 destinations are dropped
    wb(0, 32'h1111); lu(0, 32'h2222);
    sample(); chk("x0_wb", 32'(bus.rf_we), 0); advance();
    idle();
    sample(); chk("x0_lu", 32'(bus.rf_we), 0); advance();

    // Collision: WB first, buffered head next
    lu(7, 32'h77);
    tick();
    idle(); wb(3, 32'h33);
    sample(); chk("coll_wb", 32'(bus.rf_a3), 3); advance();
    idle();
    sample(); chk("coll_head", 32'(bus.rf_a3), 7); chk("coll_wd", bus.rf_wd, 32'h77); advance();

    // Starvation: WB busy continuously
    wb(4, 32'h44); lu(8, 32'h88);
    tick();
    bus.lu_valid = 0;
    for (int i = 1; i <= STARVE_LIMIT; i++) begin
      sample(); chk("starve_wait", 32'(bus.stall_req), 0); chk("starve_wb", 32'(bus.rf_a3), 4); advance();
    end
    sample(); chk("starve_req", 32'(bus.stall_req), 1); chk("starve_head", 32'(bus.rf_a3), 8); advance();
    sample(); chk("starve_drop", 32'(bus.stall_req), 0); chk("starve_wb2", 32'(bus.rf_a3), 4); advance();

    // Full FIFO, held result accepted once a slot frees
    lu(10, 32'hA0); tick();
    lu(11, 32'hB0); tick();
    lu(12, 32'hC0);
    sample(); chk("full_ready", 32'(bus.lu_ready), 0); advance();
    bus.wb_we = 0;
    sample(); chk("full_pop_ready", 32'(bus.lu_ready), 0); chk("full_pop_a3", 32'(bus.rf_a3), 10); advance();
    sample(); chk("pushpop_ready", 32'(bus.lu_ready), 1); chk("pushpop_a3", 32'(bus.rf_a3), 11); advance();
    idle();
    sample(); chk("held_entry", 32'(bus.rf_a3), 12); chk("held_wd", bus.rf_wd, 32'hC0); advance();
    sample(); chk("full_drained", 32'(bus.rf_we), 0); advance();

    // Scoreboard
    bus.issue_valid = 1; bus.issue_rd = 9; bus.chk_a1 = 9;
    sample(); chk("sb_issue_cycle", 32'(bus.hazard_stall), 0); advance();
    bus.issue_valid = 0;
    sample(); chk("sb_pending", 32'(bus.hazard_stall), 1); advance();
    lu(9, 32'h99);
    sample(); chk("sb_push", 32'(bus.hazard_stall), 1); advance();
    bus.lu_valid = 0;
    sample(); chk("sb_write_cycle", 32'(bus.hazard_stall), 1); chk("sb_write_a3", 32'(bus.rf_a3), 9); advance();
    sample(); chk("sb_cleared", 32'(bus.hazard_stall), 0); advance();
    lu(9, 32'h98); tick();
    bus.lu_valid = 0; bus.issue_valid = 1; bus.issue_rd = 9;
    sample(); chk("sb_same_cycle_a3", 32'(bus.rf_a3), 9); advance();
    bus.issue_valid = 0;
    sample(); chk("sb_set_wins", 32'(bus.hazard_stall), 1); advance();
    bus.chk_a1 = 0; bus.chk_a2 = 0; bus.chk_rd = 0;
    sample(); chk("sb_x0", 32'(bus.hazard_stall), 0); advance();
    bus.chk_rd = 9;
    sample(); chk("sb_waw", 32'(bus.hazard_stall), 1); advance();

    // Reset mid-flight
    idle(); wb(4, 32'h44); lu(13, 32'hD0); tick();
    lu(14, 32'hE0); tick();
    bus.lu_valid = 0; bus.chk_a1 = 9;
    rst = 1; lu(15, 32'hF0);
    sample();
    chk("rst_we", 32'(bus.rf_we), 0);
    chk("rst_a3", 32'(bus.rf_a3), 0);
    chk("rst_wd", bus.rf_wd, 0);
    chk("rst_ready", 32'(bus.lu_ready), 0);
    chk("rst_stall", 32'(bus.stall_req), 0);
    chk("rst_haz", 32'(bus.hazard_stall), 0);
    advance();
    rst = 0; idle(); bus.chk_a1 = 9;
    sample(); chk("post_rst_we", 32'(bus.rf_we), 0); chk("post_rst_haz", 32'(bus.hazard_stall), 0); advance();

    // Randomized traffic; WB is held stable across a stall_req cycle
    for (int c = 0; c < 400; c++) begin
      if (!e_stall) begin
        bus.wb_we = ($urandom_range(0, 3) != 0);
        bus.wb_rd = 5'($urandom_range(0, 7));
        bus.wb_data = $urandom;
      end
      bus.lu_valid = ($urandom_range(0, 2) == 0);
      bus.lu_rd = 5'($urandom_range(0, 7));
      bus.lu_data = $urandom;
      bus.issue_valid = ($urandom_range(0, 3) == 0);
      bus.issue_rd = 5'($urandom_range(0, 7));
      bus.chk_a1 = 5'($urandom_range(0, 7));
      bus.chk_a2 = 5'($urandom_range(0, 7));
      bus.chk_rd = 5'($urandom_range(0, 7));
      rst = ($urandom_range(0, 63) == 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
